elevator_car_model: RTL

ELEVATOR_CAR_MODEL -- requirements
Module: elevator_car_model

---
 rtl/elevator_car_model.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/elevator_car_model.sv
// Three-floor elevator car: timed single-floor moves plus a door open/hold/close sequence.
// Defining ELEVATOR_CAR_FAULT_DETECT_EN builds the sticky illegal-command fault flag.
module elevator_car_model #(
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic cmd_up,
   input  logic cmd_down,
   input  logic cmd_door_open,
   output logic floor_1,
   output logic floor_2,
   output logic floor_3,
   output logic moving,
   output logic door_open,
   output logic door_closed,
   output logic arrived,
   output logic fault
);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      MOVE_UP      = 3'd1,
      MOVE_DOWN    = 3'd2,
      DOOR_OPENING = 3'd3,
      DOOR_OPEN    = 3'd4,
      DOOR_CLOSING = 3'd5
   } state_t;

   localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
   localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

   state_t     state_r;
   logic [7:0] cnt_r;
   logic [2:0] floor_r;   // one-hot, bit 0 = floor 1
   logic       moving_r;
   logic       door_open_r;
   logic       door_closed_r;
   logic       arrived_r;

   // Car sequencing FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r       <= IDLE;
         cnt_r         <= 8'd0;
         floor_r       <= 3'b001;
         moving_r      <= 1'b0;
         door_open_r   <= 1'b0;
         door_closed_r <= 1'b1;
         arrived_r     <= 1'b0;
      end else begin
         arrived_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cmd_door_open) begin
                  state_r       <= DOOR_OPENING;
                  door_closed_r <= 1'b0;
                  cnt_r         <= DOOR_LOAD;
               end else if (cmd_up) begin
                  if (!floor_r[2]) begin
                     state_r  <= MOVE_UP;
                     moving_r <= 1'b1;
                     cnt_r    <= TRAVEL_LOAD;
                  end else begin
                     state_r <= IDLE;
                  end
               end else if (cmd_down) begin
                  if (!floor_r[0]) begin
                     state_r  <= MOVE_DOWN;
                     moving_r <= 1'b1;
                     cnt_r    <= TRAVEL_LOAD;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            MOVE_UP, MOVE_DOWN: begin
               if (cnt_r == 8'd0) begin
                  state_r   <= IDLE;
                  moving_r  <= 1'b0;
                  arrived_r <= 1'b1;
                  floor_r   <= (state_r == MOVE_UP) ? {floor_r[1:0], 1'b0}
                                                    : {1'b0, floor_r[2:1]};
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            DOOR_OPENING: begin
               if (cnt_r == 8'd0) begin
                  state_r     <= DOOR_OPEN;
                  door_open_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            DOOR_OPEN: begin
               if (!cmd_door_open) begin
                  state_r     <= DOOR_CLOSING;
                  door_open_r <= 1'b0;
                  cnt_r       <= DOOR_LOAD;
               end else begin
                  state_r <= DOOR_OPEN;
               end
            end
            DOOR_CLOSING: begin
               // Reopening reverses from the current position: the time spent closing is reused.
               if (cmd_door_open) begin
                  state_r <= DOOR_OPENING;
                  cnt_r   <= DOOR_LOAD - cnt_r;
               end else if (cnt_r == 8'd0) begin
                  state_r       <= IDLE;
                  door_closed_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            default: begin
               state_r       <= IDLE;
               cnt_r         <= 8'd0;
               moving_r      <= 1'b0;
               door_open_r   <= 1'b0;
               door_closed_r <= 1'b1;
            end
         endcase
      end
   end

`ifdef ELEVATOR_CAR_FAULT_DETECT_EN
   logic fault_r;
   logic door_busy_s;
   logic illegal_s;

   // Classify the current cycle's command combination as illegal or not.
   always_comb begin
      door_busy_s = (state_r == DOOR_OPENING) || (state_r == DOOR_OPEN) ||
                    (state_r == DOOR_CLOSING);
      illegal_s   = (cmd_up && cmd_down) ||
                    ((state_r == IDLE) && cmd_up && floor_r[2]) ||
                    ((state_r == IDLE) && cmd_down && floor_r[0]) ||
                    (door_busy_s && (cmd_up || cmd_down));
   end

   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fault_r <= 1'b0;
      end else begin
         fault_r <= fault_r | illegal_s;
      end
   end

   assign fault = fault_r;
`else
   assign fault = 1'b0;
`endif

   assign floor_1     = floor_r[0];
   assign floor_2     = floor_r[1];
   assign floor_3     = floor_r[2];
   assign moving      = moving_r;
   assign door_open   = door_open_r;
   assign door_closed = door_closed_r;
   assign arrived     = arrived_r;

endmodule
